// File: rtl/menu_ready_ctl.sv
// Main-menu readiness controller: debounces the local start button, exchanges
// readiness with the remote board and runs a vsync-counted countdown into GAME.
module menu_ready_ctl #(
   parameter int unsigned DEBOUNCE_CYCLES  = 650_000,
   parameter int unsigned COUNTDOWN_FRAMES = 180
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       btn,
   input  logic       remote_ready,
   input  logic       vsync,
   input  logic       game_over,
   output logic       start,
   output logic       game_en,
   output logic       local_ready,
   output logic [7:0] countdown
);

   localparam int unsigned DW = $clog2(DEBOUNCE_CYCLES);
   localparam int unsigned FW = $clog2(COUNTDOWN_FRAMES + 1);
   localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_CYCLES - 1);
   localparam logic [DW-1:0] DB_ONE  = DW'(1);
   localparam logic [FW-1:0] FR_LOAD = FW'(COUNTDOWN_FRAMES);
   localparam logic [FW-1:0] FR_ONE  = FW'(1);

   if (COUNTDOWN_FRAMES < 1 || DEBOUNCE_CYCLES < 2) begin : g_param_check
      $error("menu_ready_ctl: COUNTDOWN_FRAMES must be >= 1 and DEBOUNCE_CYCLES >= 2");
   end

   typedef enum logic [1:0] {
      ST_MENU,
      ST_LOCAL_READY,
      ST_COUNTDOWN,
      ST_GAME
   } state_t;

   logic          btn_s1, btn_s2;
   logic          rr_s1, rr_s2;
   logic          vs_q, vs_d;
   logic          tick;
   logic          stable;
   logic [DW-1:0] db_cnt;
   logic          press;
   state_t        state, state_n;
   logic [FW-1:0] frames, frames_n;
   logic [31:0]   frames_ext;
   logic [7:0]    countdown_n;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         btn_s1 <= 1'b0;
         btn_s2 <= 1'b0;
         rr_s1  <= 1'b0;
         rr_s2  <= 1'b0;
         vs_q   <= 1'b0;
         vs_d   <= 1'b0;
      end else begin
         btn_s1 <= btn;
         btn_s2 <= btn_s1;
         rr_s1  <= remote_ready;
         rr_s2  <= rr_s1;
         vs_q   <= vsync;
         vs_d   <= vs_q;
      end
   end

   assign tick = vs_q & ~vs_d;

   // press is a registered pulse on the 0->1 flip of the accepted level
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stable <= 1'b0;
         db_cnt <= '0;
         press  <= 1'b0;
      end else begin
         press <= 1'b0;
         if (btn_s2 == stable) begin
            db_cnt <= '0;
         end else if (db_cnt == DB_LAST) begin
            stable <= ~stable;
            db_cnt <= '0;
            press  <= ~stable;
         end else begin
            db_cnt <= db_cnt + DB_ONE;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state  <= ST_MENU;
         frames <= '0;
      end else begin
         state  <= state_n;
         frames <= frames_n;
      end
   end

   always_comb begin
      state_n  = state;
      frames_n = frames;
      case (state)
         ST_MENU: begin
            if (press) state_n = ST_LOCAL_READY;
         end
         ST_LOCAL_READY: begin
            if (rr_s2) begin
               state_n  = ST_COUNTDOWN;
               frames_n = FR_LOAD;
            end else if (press) begin
               state_n = ST_MENU;
            end
         end
         ST_COUNTDOWN: begin
            if (!rr_s2) begin
               state_n  = ST_LOCAL_READY;
               frames_n = '0;
            end else if (tick) begin
               if (frames == FR_ONE) begin
                  state_n  = ST_GAME;
                  frames_n = '0;
               end else begin
                  frames_n = frames - FR_ONE;
               end
            end
         end
         ST_GAME: begin
            if (game_over) state_n = ST_MENU;
         end
         default: state_n = ST_MENU;
      endcase

      frames_ext  = 32'(frames_n);
      countdown_n = '0;
      if (state_n == ST_COUNTDOWN)
         countdown_n = (frames_ext > 32'd255) ? 8'hFF : frames_ext[7:0];
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         start       <= 1'b0;
         game_en     <= 1'b0;
         local_ready <= 1'b0;
         countdown   <= '0;
      end else begin
         start       <= (state_n != ST_MENU);
         game_en     <= (state_n == ST_GAME);
         local_ready <= (state_n == ST_LOCAL_READY) || (state_n == ST_COUNTDOWN);
         countdown   <= countdown_n;
      end
   end

endmodule

// File: tb/tb_menu_ready_ctl.sv
// Scenario bench for menu_ready_ctl with DEBOUNCE_CYCLES=4, COUNTDOWN_FRAMES=3.
// Expected output words {start,game_en,local_ready,countdown} are queued, then popped at the sample point.
module tb_menu_ready_ctl;

   localparam logic [10:0] IDLE_V = 11'h000;
   localparam logic [10:0] LR_V   = 11'h500;
   localparam logic [10:0] GAME_V = 11'h600;

   logic       clk = 1'b0;
   logic       rst, btn, remote_ready, vsync, game_over;
   logic       start, game_en, local_ready;
   logic [7:0] countdown;
   logic [10:0] obs;

   typedef struct {
      string       name;
      logic [10:0] v;
   } exp_t;

   exp_t exp_q[$];
   int   passed = 0;
   int   total  = 0;

   assign obs = {start, game_en, local_ready, countdown};

   always #5 clk = ~clk;

   menu_ready_ctl #(
      .DEBOUNCE_CYCLES (4),
      .COUNTDOWN_FRAMES(3)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .btn         (btn),
      .remote_ready(remote_ready),
      .vsync       (vsync),
      .game_over   (game_over),
      .start       (start),
      .game_en     (game_en),
      .local_ready (local_ready),
      .countdown   (countdown)
   );

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic push(input string name, input logic [10:0] v);
      exp_t e;
      e.name = name;
      e.v    = v;
      exp_q.push_back(e);
   endtask

   task automatic press_btn();
      btn = 1'b1;
      tick(7);
      btn = 1'b0;
      tick(7);
   endtask

   task automatic test_reset();
      exp_t e;
      rst = 1'b1; btn = 1'b0; remote_ready = 1'b0; vsync = 1'b0; game_over = 1'b0;
      tick(2);
      push("reset_outputs", IDLE_V);
      e = exp_q.pop_front(); total++;
      if (obs !== e.v) $display("FAIL %s: got %b want %b", e.name, obs, e.v);
      else passed++;
      rst = 1'b0;
      tick(1);
   endtask

   task automatic test_bounce();
      exp_t e;
      for (int r = 0; r < 5; r++) begin
         for (int c = 0; c < 6; c++) begin
            btn = (c < 3);
            push("bounce_no_start", IDLE_V);
            tick(1);
            e = exp_q.pop_front(); total++;
            if (obs !== e.v) $display("FAIL %s: got %b want %b", e.name, obs, e.v);
            else passed++;
         end
      end
      btn = 1'b1;
      for (int k = 1; k <= 7; k++) begin
         push("press_latency", (k == 7) ? LR_V : IDLE_V);
         tick(1);
         e = exp_q.pop_front(); total++;
         if (obs !== e.v) $display("FAIL %s: got %b want %b", e.name, obs, e.v);
         else passed++;
      end
      btn = 1'b0;
      tick(7);
      push("release_no_press", LR_V);
      e = exp_q.pop_front(); total++;
      if (obs !== e.v) $display("FAIL %s: got %b want %b", e.name, obs, e.v);
      else passed++;
   endtask

   task automatic test_normal();
      exp_t e;
      logic [10:0] cur, nxt;
      remote_ready = 1'b1;
      for (int k = 1; k <= 3; k++) begin
         push("remote_latency", (k == 3) ? (LR_V | 11'd3) : LR_V);
         tick(1);
         e = exp_q.pop_front(); total++;
         if (obs !== e.v) $display("FAIL %s: got %b want %b", e.name, obs, e.v);
         else passed++;
      end
      for (int p = 0; p < 3; p++) begin
         cur = LR_V | 11'(3 - p);
         nxt = (p == 2) ? GAME_V : (LR_V | 11'(2 - p));
         vsync = 1'b1;
         push("vsync_registering", cur);
         tick(1);
         e = exp_q.pop_front(); total++;
         if (obs !== e.v) $display("FAIL %s: got %b want %b", e.name, obs, e.v);
         else passed++;
         push("vsync_step", nxt);
         tick(1);
         e = exp_q.pop_front(); total++;
         if (obs !== e.v) $display("FAIL %s: got %b want %b", e.name, obs, e.v);
         else passed++;
         vsync = 1'b0;
         tick(2);
      end
   endtask

   task automatic test_game_end();
      exp_t e;
      remote_ready = 1'b0;
      tick(4);
      push("game_ignores_remote", GAME_V);
      e = exp_q.pop_front(); total++;
      if (obs !== e.v) $display("FAIL %s: got %b want %b", e.name, obs, e.v);
      else passed++;
      game_over = 1'b1;
      tick(1);
      game_over = 1'b0;
      push("game_over_clears", IDLE_V);
      e = exp_q.pop_front(); total++;
      if (obs !== e.v) $display("FAIL %s: got %b want %b", e.name, obs, e.v);
      else passed++;
      game_over = 1'b1;
      tick(1);
      game_over = 1'b0;
      tick(1);
      push("menu_ignores_game_over", IDLE_V);
      e = exp_q.pop_front(); total++;
      if (obs !== e.v) $display("FAIL %s: got %b want %b", e.name, obs, e.v);
      else passed++;
      press_btn();
      game_over = 1'b1;
      tick(1);
      game_over = 1'b0;
      tick(1);
      push("ready_ignores_game_over", LR_V);
      e = exp_q.pop_front(); total++;
      if (obs !== e.v) $display("FAIL %s: got %b want %b", e.name, obs, e.v);
      else passed++;
   endtask

   task automatic test_cancel();
      exp_t e;
      btn = 1'b1;
      tick(6);
      push("cancel_before_press", LR_V);
      e = exp_q.pop_front(); total++;
      if (obs !== e.v) $display("FAIL %s: got %b want %b", e.name, obs, e.v);
      else passed++;
      tick(1);
      push("cancel_to_menu", IDLE_V);
      e = exp_q.pop_front(); total++;
      if (obs !== e.v) $display("FAIL %s: got %b want %b", e.name, obs, e.v);
      else passed++;
      btn = 1'b0;
      tick(7);
      press_btn();
      // press pulse and synced remote_ready both land in the cycle before edge 7
      btn = 1'b1;
      tick(4);
      remote_ready = 1'b1;
      tick(3);
      push("press_and_remote_same_cycle", LR_V | 11'd3);
      e = exp_q.pop_front(); total++;
      if (obs !== e.v) $display("FAIL %s: got %b want %b", e.name, obs, e.v);
      else passed++;
      btn = 1'b0;
      tick(7);
      push("countdown_holds", LR_V | 11'd3);
      e = exp_q.pop_front(); total++;
      if (obs !== e.v) $display("FAIL %s: got %b want %b", e.name, obs, e.v);
      else passed++;
   endtask

   task automatic test_remote_drop();
      exp_t e;
      vsync = 1'b1;
      tick(2);
      vsync = 1'b0;
      tick(2);
      push("drop_setup", LR_V | 11'd2);
      e = exp_q.pop_front(); total++;
      if (obs !== e.v) $display("FAIL %s: got %b want %b", e.name, obs, e.v);
      else passed++;
      remote_ready = 1'b0;
      tick(2);
      push("drop_not_yet", LR_V | 11'd2);
      e = exp_q.pop_front(); total++;
      if (obs !== e.v) $display("FAIL %s: got %b want %b", e.name, obs, e.v);
      else passed++;
      tick(1);
      push("drop_to_ready", LR_V);
      e = exp_q.pop_front(); total++;
      if (obs !== e.v) $display("FAIL %s: got %b want %b", e.name, obs, e.v);
      else passed++;
      remote_ready = 1'b1;
      tick(3);
      push("restart_countdown", LR_V | 11'd3);
      e = exp_q.pop_front(); total++;
      if (obs !== e.v) $display("FAIL %s: got %b want %b", e.name, obs, e.v);
      else passed++;
   endtask

   task automatic test_async_reset();
      exp_t e;
      #2;
      rst = 1'b1;
      push("async_reset_immediate", IDLE_V);
      #1;
      e = exp_q.pop_front(); total++;
      if (obs !== e.v) $display("FAIL %s: got %b want %b", e.name, obs, e.v);
      else passed++;
      tick(1);
      rst = 1'b0;
      btn = 1'b1;
      for (int k = 1; k <= 7; k++) begin
         push("fresh_debounce", (k == 7) ? LR_V : IDLE_V);
         tick(1);
         e = exp_q.pop_front(); total++;
         if (obs !== e.v) $display("FAIL %s: got %b want %b", e.name, obs, e.v);
         else passed++;
      end
      btn = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      test_reset();
      test_bounce();
      test_normal();
      test_game_end();
      test_cancel();
      test_remote_drop();
      test_async_reset();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
